// File: rtl/n64_pi_prefetch_engine.sv
// Purpose: PI address counter + bank access sequencer with a one-entry sequential read prefetch buffer.
// Latency: buffer hit returns data the cycle after the read pulse; a miss returns data the cycle after i_ack.
// Backpressure: o_pi_busy marks outstanding demand work (pulses then are ignored); o_request is held until i_ack.
// Optional: define N64_PI_PREFETCH_STATS_EN to add saturating hit/miss counters (o_hit_count, o_miss_count).

`ifndef BANK_INVALID
`define BANK_INVALID 4'h0
`endif

module n64_pi_prefetch_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 26
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pi_address_load,
    input  logic [31:0]       i_pi_address,
    input  logic              i_pi_read,
    input  logic              i_pi_write,
    input  logic [DATA_W-1:0] i_pi_wdata,
    output logic [DATA_W-1:0] o_pi_rdata,
    output logic              o_pi_rdata_valid,
    output logic              o_pi_busy,
    output logic [31:0]       o_pi_address,
    input  logic [3:0]        i_bank,
    input  logic              i_bank_prefetch,
    input  logic [ADDR_W-1:0] i_translated_address,
    output logic              o_request,
    output logic              o_write,
    output logic [3:0]        o_bank,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_wdata,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_rdata
`ifdef N64_PI_PREFETCH_STATS_EN
    ,
    output logic [15:0]       o_hit_count,
    output logic [15:0]       o_miss_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEMAND_RD,
        ST_DEMAND_WR,
        ST_PREFETCH_ISSUE,
        ST_PREFETCH_WAIT
    } state_t;

    state_t state;

    // access that produced the current/last transaction; seeds the next prefetch
    logic [3:0]        cap_bank;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_pf;

    // prefetch buffer; bank/addr double as the tag of an in-flight prefetch
    logic              buf_vld;
    logic [3:0]        buf_bank;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_dat;

    // PI access that arrived while a prefetch occupied the bank port
    logic              pend_vld;
    logic              pend_wr;
    logic              pend_hit;
    logic [3:0]        pend_bank;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_pf;
    logic [DATA_W-1:0] pend_wdata;

    // outstanding request was orphaned by an address load
    logic              discard;

    logic              acc, acc_rd, acc_wr;
    logic [ADDR_W:0]   pf_sum;
    logic [ADDR_W-1:0] pf_addr;
    logic              pf_ovf;
    logic              idle_like;
    logic [3:0]        tag_bank;
    logic [ADDR_W-1:0] tag_addr;
    logic              src_go, src_wr, src_rd, src_pf, src_bank_ok, src_buf_hit;
    logic [3:0]        src_bank;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;

    assign acc    = (i_pi_read | i_pi_write) & ~i_pi_address_load & ~o_pi_busy;
    assign acc_rd = acc & i_pi_read;
    assign acc_wr = acc & ~i_pi_read;

    assign pf_sum  = {1'b0, cap_addr} + (ADDR_W+1)'(2);
    assign pf_addr = pf_sum[ADDR_W-1:0];
    assign pf_ovf  = pf_sum[ADDR_W];

    // an overflowing prefetch collapses straight back to idle, so it takes idle's decisions this cycle
    assign idle_like = (state == ST_IDLE) || ((state == ST_PREFETCH_ISSUE) && pf_ovf);

    assign tag_bank = (state == ST_PREFETCH_ISSUE) ? cap_bank : buf_bank;
    assign tag_addr = (state == ST_PREFETCH_ISSUE) ? pf_addr  : buf_addr;

    // idle serves a parked access first, otherwise the live pulse (mutually exclusive via busy)
    assign src_go      = pend_vld | acc;
    assign src_wr      = pend_vld ? pend_wr    : acc_wr;
    assign src_rd      = src_go & ~src_wr;
    assign src_bank    = pend_vld ? pend_bank  : i_bank;
    assign src_addr    = pend_vld ? pend_addr  : i_translated_address;
    assign src_pf      = pend_vld ? pend_pf    : i_bank_prefetch;
    assign src_wdata   = pend_vld ? pend_wdata : i_pi_wdata;
    assign src_bank_ok = (src_bank != `BANK_INVALID);
    assign src_buf_hit = buf_vld && (src_bank == buf_bank) && (src_addr == buf_addr);

    // main sequencer: counter, bank port, prefetch buffer and PI return path
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            o_pi_rdata       <= '0;
            o_pi_rdata_valid <= 1'b0;
            o_pi_busy        <= 1'b0;
            o_pi_address     <= '0;
            o_request        <= 1'b0;
            o_write          <= 1'b0;
            o_bank           <= '0;
            o_address        <= '0;
            o_wdata          <= '0;
            cap_bank         <= '0;
            cap_addr         <= '0;
            cap_pf           <= 1'b0;
            buf_vld          <= 1'b0;
            buf_bank         <= '0;
            buf_addr         <= '0;
            buf_dat          <= '0;
            pend_vld         <= 1'b0;
            pend_wr          <= 1'b0;
            pend_hit         <= 1'b0;
            pend_bank        <= '0;
            pend_addr        <= '0;
            pend_pf          <= 1'b0;
            pend_wdata       <= '0;
            discard          <= 1'b0;
        end else begin
            o_pi_rdata_valid <= 1'b0;
            if (acc) o_pi_address <= o_pi_address + 32'd2;

            if (idle_like) begin
                state     <= ST_IDLE;
                o_pi_busy <= 1'b0;
                pend_vld  <= 1'b0;
                if (src_go) begin
                    cap_bank <= src_bank;
                    cap_addr <= src_addr;
                    cap_pf   <= src_pf;
                    if (src_wr) begin
                        buf_vld <= 1'b0;
                        if (src_bank_ok) begin
                            o_request <= 1'b1;
                            o_write   <= 1'b1;
                            o_bank    <= src_bank;
                            o_address <= src_addr;
                            o_wdata   <= src_wdata;
                            o_pi_busy <= 1'b1;
                            state     <= ST_DEMAND_WR;
                        end
                    end else if (!src_bank_ok) begin
                        o_pi_rdata       <= '0;
                        o_pi_rdata_valid <= 1'b1;
                    end else if (src_buf_hit) begin
                        o_pi_rdata       <= buf_dat;
                        o_pi_rdata_valid <= 1'b1;
                        buf_vld          <= 1'b0;
                        if (src_pf) state <= ST_PREFETCH_ISSUE;
                    end else begin
                        o_request <= 1'b1;
                        o_write   <= 1'b0;
                        o_bank    <= src_bank;
                        o_address <= src_addr;
                        o_pi_busy <= 1'b1;
                        state     <= ST_DEMAND_RD;
                    end
                end
            end else begin
                case (state)
                    ST_DEMAND_RD: begin
                        if (i_ack) begin
                            o_request <= 1'b0;
                            o_pi_busy <= 1'b0;
                            discard   <= 1'b0;
                            if (discard) begin
                                state <= ST_IDLE;
                            end else begin
                                o_pi_rdata       <= i_rdata;
                                o_pi_rdata_valid <= 1'b1;
                                state            <= cap_pf ? ST_PREFETCH_ISSUE : ST_IDLE;
                            end
                        end
                    end
                    ST_DEMAND_WR: begin
                        if (i_ack) begin
                            o_request <= 1'b0;
                            o_write   <= 1'b0;
                            o_pi_busy <= 1'b0;
                            discard   <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_PREFETCH_ISSUE: begin
                        o_request <= 1'b1;
                        o_write   <= 1'b0;
                        o_bank    <= cap_bank;
                        o_address <= pf_addr;
                        buf_bank  <= cap_bank;
                        buf_addr  <= pf_addr;
                        buf_vld   <= 1'b0;
                        state     <= ST_PREFETCH_WAIT;
                    end
                    ST_PREFETCH_WAIT: begin
                        if (i_ack) begin
                            o_request <= 1'b0;
                            state     <= ST_IDLE;
                            if (discard) begin
                                discard   <= 1'b0;
                                o_pi_busy <= 1'b0;
                            end else if (pend_vld && pend_hit) begin
                                // hit-in-flight: forward, buffer stays empty, chain the next prefetch
                                o_pi_rdata       <= i_rdata;
                                o_pi_rdata_valid <= 1'b1;
                                o_pi_busy        <= 1'b0;
                                pend_vld         <= 1'b0;
                                cap_bank         <= pend_bank;
                                cap_addr         <= pend_addr;
                                cap_pf           <= pend_pf;
                                if (pend_pf) state <= ST_PREFETCH_ISSUE;
                            end else if (!pend_vld) begin
                                buf_dat <= i_rdata;
                                buf_vld <= 1'b1;
                            end
                            // a non-matching parked access drops the data and is served by idle next
                        end
                    end
                    default: state <= ST_IDLE;
                endcase

                // park a PI access while the bank port is busy with a prefetch
                if (acc && ((state == ST_PREFETCH_ISSUE) || (state == ST_PREFETCH_WAIT))) begin
                    pend_vld   <= 1'b1;
                    pend_wr    <= acc_wr;
                    pend_hit   <= acc_rd && (i_bank == tag_bank) && (i_translated_address == tag_addr);
                    pend_bank  <= i_bank;
                    pend_addr  <= i_translated_address;
                    pend_pf    <= i_bank_prefetch;
                    pend_wdata <= i_pi_wdata;
                    o_pi_busy  <= 1'b1;
                end
            end

            // address load wins over everything; an unacked request keeps running but is orphaned
            if (i_pi_address_load) begin
                o_pi_address <= i_pi_address;
                buf_vld      <= 1'b0;
                pend_vld     <= 1'b0;
                if (o_request && !i_ack) begin
                    discard <= 1'b1;
                end else begin
                    state            <= ST_IDLE;
                    o_request        <= 1'b0;
                    o_write          <= 1'b0;
                    o_pi_busy        <= 1'b0;
                    o_pi_rdata_valid <= 1'b0;
                    discard          <= 1'b0;
                end
            end
        end
    end

`ifdef N64_PI_PREFETCH_STATS_EN
    logic hit_now, miss_now;

    assign hit_now  = (idle_like && src_rd && src_bank_ok && src_buf_hit) ||
                      ((state == ST_PREFETCH_WAIT) && i_ack && !discard && pend_vld && pend_hit);
    assign miss_now = idle_like && src_rd && src_bank_ok && !src_buf_hit && src_pf;

    // saturating hit/miss statistics, restarted by an address load
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else if (i_pi_address_load) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            if (hit_now && (o_hit_count != 16'hFFFF))   o_hit_count  <= o_hit_count + 16'd1;
            if (miss_now && (o_miss_count != 16'hFFFF)) o_miss_count <= o_miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_n64_pi_prefetch_engine.sv
// Purpose: directed self-checking bench for n64_pi_prefetch_engine.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at that same point.
// Backpressure: the bank side is modelled by hand-driven i_ack pulses.

module tb_n64_pi_prefetch_engine;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 26;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld;
    logic [31:0]       ld_addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pi_rdata;
    logic              pi_rdata_valid;
    logic              pi_busy;
    logic [31:0]       pi_address;
    logic [3:0]        bank;
    logic              bank_pf;
    logic [ADDR_W-1:0] taddr;
    logic              req;
    logic              req_wr;
    logic [3:0]        req_bank;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ack;
    logic [DATA_W-1:0] ack_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // bank decoder: 0x1Exx_xxxx cart (no prefetch), 0x1xxx_xxxx ROM (prefetch), else invalid (bank 0)
    always_comb begin
        taddr = pi_address[ADDR_W-1:0];
        if (pi_address[31:24] == 8'h1E) begin
            bank    = 4'd2;
            bank_pf = 1'b0;
        end else if (pi_address[31:28] == 4'h1) begin
            bank    = 4'd1;
            bank_pf = 1'b1;
        end else begin
            bank    = 4'd0;
            bank_pf = 1'b0;
        end
    end

    n64_pi_prefetch_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_pi_address_load    (ld),
        .i_pi_address         (ld_addr),
        .i_pi_read            (rd),
        .i_pi_write           (wr),
        .i_pi_wdata           (wdata),
        .o_pi_rdata           (pi_rdata),
        .o_pi_rdata_valid     (pi_rdata_valid),
        .o_pi_busy            (pi_busy),
        .o_pi_address         (pi_address),
        .i_bank               (bank),
        .i_bank_prefetch      (bank_pf),
        .i_translated_address (taddr),
        .o_request            (req),
        .o_write              (req_wr),
        .o_bank               (req_bank),
        .o_address            (req_addr),
        .o_wdata              (req_wdata),
        .i_ack                (ack),
        .i_rdata              (ack_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] a);
        ld_addr = a;
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    task automatic do_read();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d);
        wdata = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic do_ack(input logic [DATA_W-1:0] d);
        ack_data = d;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ld = 1'b0; ld_addr = '0; rd = 1'b0; wr = 1'b0;
        wdata = '0; ack = 1'b0; ack_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_pi_address", pi_address, 32'h0);
        check("rst_request", req, 1'b0);
        check("rst_busy", pi_busy, 1'b0);
        check("rst_valid", pi_rdata_valid, 1'b0);
        check("rst_rdata", pi_rdata, 16'h0);

        // demand read miss on ROM, then prefetch of +2
        do_load(32'h1000_0000);
        check("t1_load_addr", pi_address, 32'h1000_0000);
        do_read();
        check("t1_req", req, 1'b1);
        check("t1_req_addr", req_addr, 32'h0);
        check("t1_req_bank", req_bank, 4'd1);
        check("t1_req_wr", req_wr, 1'b0);
        check("t1_busy", pi_busy, 1'b1);
        check("t1_counter", pi_address, 32'h1000_0002);
        check("t1_no_early_valid", pi_rdata_valid, 1'b0);
        tick(); tick();
        check("t1_req_held", req, 1'b1);
        do_ack(16'hA5A5);
        check("t1_valid", pi_rdata_valid, 1'b1);
        check("t1_rdata", pi_rdata, 16'hA5A5);
        check("t1_req_drop", req, 1'b0);
        check("t1_busy_clear", pi_busy, 1'b0);
        tick();
        check("t1_pf_req", req, 1'b1);
        check("t1_pf_addr", req_addr, 32'h2);
        check("t1_pf_busy", pi_busy, 1'b0);
        check("t1_valid_once", pi_rdata_valid, 1'b0);

        // buffer hit completes in one cycle and chains the next prefetch
        do_ack(16'h1234);
        check("t2_pf_done", req, 1'b0);
        do_read();
        check("t2_hit_valid", pi_rdata_valid, 1'b1);
        check("t2_hit_rdata", pi_rdata, 16'h1234);
        check("t2_no_demand", req, 1'b0);
        check("t2_counter", pi_address, 32'h1000_0004);
        tick();
        check("t2_pf_req", req, 1'b1);
        check("t2_pf_addr", req_addr, 32'h4);

        // read matching the in-flight prefetch
        do_read();
        check("t3_busy", pi_busy, 1'b1);
        check("t3_same_req", req_addr, 32'h4);
        check("t3_no_valid", pi_rdata_valid, 1'b0);
        tick();
        do_ack(16'hBEEF);
        check("t3_valid", pi_rdata_valid, 1'b1);
        check("t3_rdata", pi_rdata, 16'hBEEF);
        check("t3_req_drop", req, 1'b0);
        check("t3_busy_clear", pi_busy, 1'b0);
        tick();
        check("t3_next_pf", req_addr, 32'h6);

        // write while a prefetch is outstanding
        do_write(16'h5A5A);
        check("t4_busy", pi_busy, 1'b1);
        check("t4_pf_still", req_wr, 1'b0);
        do_ack(16'hDEAD);
        check("t4_pf_discard", pi_rdata_valid, 1'b0);
        check("t4_busy_hold", pi_busy, 1'b1);
        tick();
        check("t4_wr_req", req, 1'b1);
        check("t4_wr_flag", req_wr, 1'b1);
        check("t4_wr_addr", req_addr, 32'h6);
        check("t4_wr_data", req_wdata, 16'h5A5A);
        do_ack(16'h0000);
        check("t4_wr_done", req, 1'b0);
        check("t4_wr_busy", pi_busy, 1'b0);
        do_read();
        check("t4_miss_req", req, 1'b1);
        check("t4_miss_addr", req_addr, 32'h8);
        do_ack(16'h0808);
        check("t4_miss_rdata", pi_rdata, 16'h0808);
        tick();
        check("t4_pf_addr", req_addr, 32'hA);

        // address load mid-prefetch to the cart bank
        do_load(32'h1E00_0000);
        check("t5_load_addr", pi_address, 32'h1E00_0000);
        check("t5_req_kept", req, 1'b1);
        do_ack(16'h7777);
        check("t5_stale_valid", pi_rdata_valid, 1'b0);
        check("t5_stale_req", req, 1'b0);
        do_read();
        check("t5_req", req, 1'b1);
        check("t5_bank", req_bank, 4'd2);
        check("t5_addr", req_addr, 32'h0200_0000);
        do_ack(16'h4242);
        check("t5_valid", pi_rdata_valid, 1'b1);
        check("t5_rdata", pi_rdata, 16'h4242);
        tick();
        check("t5_no_pf", req, 1'b0);

        // invalid bank read
        do_load(32'h0000_0000);
        do_read();
        check("t6_valid", pi_rdata_valid, 1'b1);
        check("t6_rdata", pi_rdata, 16'h0000);
        check("t6_no_req", req, 1'b0);
        check("t6_counter", pi_address, 32'h2);
        tick();
        check("t6_no_req_later", req, 1'b0);

        // prefetch suppressed at top of translated address space
        do_load(32'h13FF_FFFE);
        do_read();
        check("t7_addr", req_addr, 32'h03FF_FFFE);
        do_ack(16'h1111);
        check("t7_rdata", pi_rdata, 16'h1111);
        tick();
        check("t7_no_pf", req, 1'b0);
        tick();
        check("t7_no_pf_later", req, 1'b0);

        // ignored pulse while busy, then async reset mid demand read
        do_load(32'h1000_0000);
        do_read();
        check("t8_req", req, 1'b1);
        do_read();
        check("t8_ignored_counter", pi_address, 32'h1000_0002);
        check("t8_ignored_addr", req_addr, 32'h0);
        rst = 1'b1;
        #1;
        check("t8_async_req", req, 1'b0);
        check("t8_async_busy", pi_busy, 1'b0);
        check("t8_async_counter", pi_address, 32'h0);
        tick();
        rst = 1'b0;
        do_ack(16'h9999);
        check("t8_late_ack_valid", pi_rdata_valid, 1'b0);
        check("t8_late_ack_req", req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
